// File: rtl/tdm_deframer.sv
// tdm_deframer -- recovers 4-bit words from a serial TDM stream with frame sync.
//
// Ports:
//   clk        rising-edge clock, one serial slot per cycle
//   reset      synchronous, active-low reset
//   sd_in      serial TDM data, one slot per clk
//   fs_in      frame sync, high in the cycle sd_in carries slot 0
//   word_out   recovered word, bit k taken from slot k
//   word_valid word_out holds an undelivered word
//   word_ready downstream accepts when word_valid && word_ready on a rising edge
//   lock       high while the framer state is LOCKED
//   overrun    one-cycle pulse when a completed word is dropped
//   parity_err parity flag travelling with the buffered word
//
// Build option: define TDM_DEFRAMER_PARITY_EN for a 5-slot frame whose slot 4
// carries even parity over bits 3..0; otherwise the frame is 4 slots and
// parity_err stays 0.
module tdm_deframer (
  input  logic       clk,
  input  logic       reset,
  input  logic       sd_in,
  input  logic       fs_in,
  output logic [3:0] word_out,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       lock,
  output logic       overrun,
  output logic       parity_err
);

`ifdef TDM_DEFRAMER_PARITY_EN
  localparam logic [2:0] LAST_SLOT = 3'd4;
`else
  localparam logic [2:0] LAST_SLOT = 3'd3;
`endif

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [2:0] slot_r, slot_s;
  logic [1:0] miss_r, miss_s;
  logic [3:0] shift_r, shift_s;
  logic       complete_s;
  logic [3:0] new_word_s;
  logic       new_perr_s;

  // Non-zero when data bits plus the parity slot do not have even parity.
  function automatic logic even_parity_err(input logic [3:0] bits, input logic par);
    return (^bits) ^ par;
  endfunction

  // Completed word and its parity flag, as seen on the cycle the last slot is sampled.
  always_comb begin
`ifdef TDM_DEFRAMER_PARITY_EN
    new_word_s = shift_r;
    new_perr_s = even_parity_err(shift_r, sd_in);
`else
    new_word_s = {sd_in, shift_r[2:0]};
    new_perr_s = 1'b0;
`endif
  end

  // Framer next-state: alignment FSM, slot counter, miss counter and shift bits.
  always_comb begin
    state_s    = state_r;
    slot_s     = slot_r;
    miss_s     = miss_r;
    shift_s    = shift_r;
    complete_s = 1'b0;
    case (state_r)
      HUNT: begin
        if (fs_in) begin
          shift_s = {3'b000, sd_in};
          slot_s  = 3'd1;
          miss_s  = 2'd0;
          state_s = ALIGN;
        end else begin
          state_s = HUNT;
        end
      end
      ALIGN, LOCKED: begin
        if (fs_in && (slot_r != 3'd0)) begin
          // Sync in mid-frame: this cycle becomes slot 0 and the partial word is lost.
          shift_s = {3'b000, sd_in};
          slot_s  = 3'd1;
          miss_s  = 2'd0;
          state_s = ALIGN;
        end else begin
          if (slot_r < 3'd4) begin
            shift_s[slot_r[1:0]] = sd_in;
          end else begin
            shift_s = shift_r;
          end
          slot_s = (slot_r == LAST_SLOT) ? 3'd0 : (slot_r + 3'd1);
          if (slot_r == 3'd0) begin
            if (state_r == ALIGN) begin
              state_s = fs_in ? LOCKED : HUNT;
              slot_s  = fs_in ? 3'd1 : 3'd0;
              miss_s  = 2'd0;
            end else if (fs_in) begin
              miss_s = 2'd0;
            end else if (miss_r == 2'd1) begin
              // Second consecutive missing sync: give up the lock.
              state_s = HUNT;
              slot_s  = 3'd0;
              miss_s  = 2'd0;
            end else begin
              miss_s = miss_r + 2'd1;
            end
          end else begin
            miss_s = miss_r;
          end
          if ((state_r == LOCKED) && (slot_r == LAST_SLOT)) begin
            complete_s = 1'b1;
          end else begin
            complete_s = 1'b0;
          end
        end
      end
      default: begin
        state_s = HUNT;
        slot_s  = 3'd0;
        miss_s  = 2'd0;
        shift_s = 4'd0;
      end
    endcase
  end

  // Framer state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= HUNT;
      slot_r  <= 3'd0;
      miss_r  <= 2'd0;
      shift_r <= 4'd0;
      lock    <= 1'b0;
    end else begin
      state_r <= state_s;
      slot_r  <= slot_s;
      miss_r  <= miss_s;
      shift_r <= shift_s;
      lock    <= (state_s == LOCKED);
    end
  end

  // One-entry output buffer; a full, unaccepted buffer drops the new word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_out   <= 4'd0;
      word_valid <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete_s) begin
        if (!word_valid || word_ready) begin
          word_out   <= new_word_s;
          word_valid <= 1'b1;
          parity_err <= new_perr_s;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
        parity_err <= 1'b0;
      end else begin
        word_valid <= word_valid;
      end
    end
  end

endmodule

// File: tb/tb_tdm_deframer.sv
// Directed bench for tdm_deframer: reset, lock-up, back-pressure/overrun,
// missed syncs, mid-frame sync, reset mid-frame and the parity flag.
module tb_tdm_deframer;

`ifdef TDM_DEFRAMER_PARITY_EN
  localparam int   N        = 5;
  localparam logic PERR_BAD = 1'b1;
`else
  localparam int   N        = 4;
  localparam logic PERR_BAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       sd_in;
  logic       fs_in;
  logic [3:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic       lock;
  logic       overrun;
  logic       parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  tdm_deframer dut (
    .clk        (clk),
    .reset      (reset),
    .sd_in      (sd_in),
    .fs_in      (fs_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .lock       (lock),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Send slots first..last of a frame carrying w; fs on slot 0 if fs0;
  // slot 4 (parity build) carries even parity, inverted when bad is set.
  task automatic frame_part(input logic [3:0] w, input logic fs0, input logic bad,
                            input int first, input int last);
    for (int i = first; i <= last; i++) begin
      sd_in = (i < 4) ? w[i] : ((^w) ^ bad);
      fs_in = fs0 && (i == 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input logic [3:0] w, input logic fs0, input logic bad);
    frame_part(w, fs0, bad, 0, N - 1);
  endtask

  initial begin
    reset      = 1'b0;
    sd_in      = 1'b0;
    fs_in      = 1'b0;
    word_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_lock",    {3'b000, lock},       4'h0);
    check("rst_valid",   {3'b000, word_valid}, 4'h0);
    check("rst_word",    word_out,             4'h0);
    check("rst_overrun", {3'b000, overrun},    4'h0);
    check("rst_perr",    {3'b000, parity_err}, 4'h0);

    // Acquire lock on frames of 4'hA.
    reset      = 1'b1;
    word_ready = 1'b1;
    frame(4'hA, 1'b1, 1'b0);
    check("align_lock",  {3'b000, lock},       4'h0);
    check("align_valid", {3'b000, word_valid}, 4'h0);
    frame_part(4'hA, 1'b1, 1'b0, 0, 0);
    check("lock_rise",   {3'b000, lock},       4'h1);
    frame_part(4'hA, 1'b1, 1'b0, 1, N - 1);
    check("first_valid", {3'b000, word_valid}, 4'h1);
    check("first_word",  word_out,             4'hA);

    // Back-pressure: 3 loads, 5 and 6 are dropped with overrun pulses.
    frame_part(4'h3, 1'b1, 1'b0, 0, 0);
    check("a_accepted",  {3'b000, word_valid}, 4'h0);
    word_ready = 1'b0;
    frame_part(4'h3, 1'b1, 1'b0, 1, N - 1);
    check("w3_valid",    {3'b000, word_valid}, 4'h1);
    check("w3_word",     word_out,             4'h3);
    check("w3_no_ovr",   {3'b000, overrun},    4'h0);
    frame(4'h5, 1'b1, 1'b0);
    check("ovr1_pulse",  {3'b000, overrun},    4'h1);
    check("ovr1_hold",   word_out,             4'h3);
    frame_part(4'h6, 1'b1, 1'b0, 0, 0);
    check("ovr1_end",    {3'b000, overrun},    4'h0);
    frame_part(4'h6, 1'b1, 1'b0, 1, N - 1);
    check("ovr2_pulse",  {3'b000, overrun},    4'h1);
    check("ovr2_hold",   word_out,             4'h3);
    check("ovr2_valid",  {3'b000, word_valid}, 4'h1);
    word_ready = 1'b1;
    frame_part(4'h9, 1'b1, 1'b0, 0, 0);
    check("w3_accepted", {3'b000, word_valid}, 4'h0);
    frame_part(4'h9, 1'b1, 1'b0, 1, N - 1);
    check("w9_word",     word_out,             4'h9);

    // Missed syncs: one miss keeps lock, two consecutive misses drop it.
    frame(4'hC, 1'b0, 1'b0);
    check("miss1_lock",  {3'b000, lock},       4'h1);
    check("miss1_word",  word_out,             4'hC);
    frame(4'h5, 1'b1, 1'b0);
    check("resync_lock", {3'b000, lock},       4'h1);
    check("resync_word", word_out,             4'h5);
    frame(4'h6, 1'b0, 1'b0);
    check("miss_a_lock", {3'b000, lock},       4'h1);
    frame_part(4'h0, 1'b0, 1'b0, 0, 0);
    check("miss2_lock",  {3'b000, lock},       4'h0);
    check("miss2_valid", {3'b000, word_valid}, 4'h0);
    frame_part(4'h0, 1'b0, 1'b0, 1, N - 1);

    // Re-acquire, then a sync injected at slot 2.
    frame(4'h5, 1'b1, 1'b0);
    frame(4'h5, 1'b1, 1'b0);
    check("relock",      {3'b000, lock},       4'h1);
    check("relock_word", word_out,             4'h5);
    frame_part(4'hF, 1'b1, 1'b0, 0, 1);
    sd_in = 1'b1;
    fs_in = 1'b1;
    @(posedge clk); #1;
    check("inject_lock", {3'b000, lock},       4'h0);
    frame_part(4'h2, 1'b0, 1'b0, 1, N - 1);
    check("inject_drop", {3'b000, word_valid}, 4'h0);
    frame_part(4'h2, 1'b1, 1'b0, 0, 0);
    check("inject_relk", {3'b000, lock},       4'h1);
    frame_part(4'h2, 1'b1, 1'b0, 1, N - 1);
    check("w2_word",     word_out,             4'h2);
    check("w2_valid",    {3'b000, word_valid}, 4'h1);

    // Reset at slot 2 of a locked frame with word 2 still buffered.
    word_ready = 1'b0;
    frame_part(4'h3, 1'b1, 1'b0, 0, 1);
    reset = 1'b0;
    sd_in = 1'b0;
    fs_in = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", {3'b000, word_valid}, 4'h0);
    check("mid_rst_lock",  {3'b000, lock},       4'h0);
    check("mid_rst_ovr",   {3'b000, overrun},    4'h0);
    check("mid_rst_word",  word_out,             4'h0);
    reset = 1'b1;
    frame(4'h5, 1'b0, 1'b0);
    frame(4'h5, 1'b0, 1'b0);
    check("no_fs_lock",  {3'b000, lock},       4'h0);
    check("no_fs_valid", {3'b000, word_valid}, 4'h0);

    // Parity flag: good parity, then slot 4 inverted (flag only in the parity build).
    word_ready = 1'b1;
    frame(4'h7, 1'b1, 1'b0);
    frame(4'h7, 1'b1, 1'b0);
    check("par_ok_word", word_out,             4'h7);
    check("par_ok_flag", {3'b000, parity_err}, 4'h0);
    frame(4'h7, 1'b1, 1'b1);
    check("par_bad_flag",  {3'b000, parity_err}, {3'b000, PERR_BAD});
    check("par_bad_valid", {3'b000, word_valid}, 4'h1);
    check("par_bad_word",  word_out,             4'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_deframer.md
TDM_DEFRAMER -- requirements
Module: tdm_deframer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: rising-edge clock; one serial slot per cycle.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-003 The block SHALL have port sd_in, input, 1 bit: serial TDM data, one slot per clk.
REQ-004 The block SHALL have port fs_in, input, 1 bit: frame sync, high in the cycle sd_in carries slot 0.
REQ-005 The block SHALL have port word_out, output, 4 bits: recovered word, bit k taken from slot k.
REQ-006 The block SHALL have port word_valid, output, 1 bit: word_out holds an undelivered word.
REQ-007 The block SHALL have port word_ready, input, 1 bit: downstream accepts the word when word_valid and word_ready are both high on a rising edge.
REQ-008 The block SHALL have port lock, output, 1 bit: high while the state is LOCKED.
REQ-009 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed word is dropped.
REQ-010 The block SHALL have port parity_err, output, 1 bit: parity flag qualified by word_valid.

Function
REQ-011 The frame length N SHALL be 4 slots, or 5 slots when PARITY_EN is defined; slot index counts 0..N-1 and then wraps to 0.
REQ-012 The states SHALL be HUNT, ALIGN and LOCKED, encoded in a 2-bit register.
REQ-013 In HUNT, when fs_in=1, the block SHALL capture sd_in as bit 0, set the next slot to 1 and move to ALIGN; when fs_in=0, it SHALL stay in HUNT and capture nothing.
REQ-014 In ALIGN and LOCKED, the block SHALL store sd_in into bit[slot] for slots 0..3 each cycle, then advance the slot with wrap at N-1.
REQ-015 In ALIGN, at slot 0: fs_in=1 SHALL move to LOCKED; fs_in=0 SHALL move to HUNT.
REQ-016 In ALIGN, fs_in=1 at any slot other than 0 SHALL restart alignment: treat that cycle as slot 0 and remain in ALIGN.
REQ-017 In LOCKED, fs_in=0 at slot 0 SHALL increment a 2-bit miss counter; reaching 2 consecutive misses SHALL move to HUNT.
REQ-018 In LOCKED, fs_in=1 at slot 0 SHALL clear the miss counter.
REQ-019 In LOCKED, fs_in=1 at any slot other than 0 SHALL move to ALIGN, discard the partial word, and treat that cycle as slot 0.
REQ-020 A word SHALL complete only in LOCKED, on the cycle slot N-1 is sampled; word_valid SHALL rise on the next cycle, giving 1 cycle of latency from the last slot.
REQ-021 The output buffer SHALL be one entry; word_out, word_valid and parity_err SHALL hold stable while word_valid=1 and word_ready=0.
REQ-022 If a word completes while the buffer is full and word_ready=0, the new word SHALL be dropped, overrun SHALL pulse for 1 cycle, and the held word SHALL be kept.
REQ-023 If a word completes while word_valid=1 and word_ready=1, the new word SHALL load with no gap and no overrun.
REQ-024 A transition out of LOCKED SHALL NOT clear an already buffered word.
REQ-025 lock SHALL be registered and equal (state==LOCKED).

Reset
REQ-026 When reset=0 on a clock edge, the block SHALL set state=HUNT, slot=0, miss counter=0 and clear the shift bits.
REQ-027 When reset=0 on a clock edge, the block SHALL set word_out=0, word_valid=0, overrun=0, parity_err=0 and lock=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial word and the buffered word; after reset releases, the block SHALL require a fresh fs_in to start alignment.

Configuration
REQ-029 When macro TDM_DEFRAMER_PARITY_EN is defined, N SHALL be 5, and slot 4 SHALL carry even parity over bits 3..0.
REQ-030 When the macro is defined, parity_err SHALL be registered with the word and SHALL equal (XOR of bits 3..0) XOR slot 4; a word with parity_err=1 SHALL still be delivered.
REQ-031 When the macro is undefined, N SHALL be 4 and parity_err SHALL be tied to 0; the port list SHALL be unchanged.

Verification
REQ-032 Reset then frames 1010b (LSB first: slots 0,1,0,1) with fs_in every 4th cycle and word_ready=1 -> lock rises at the second fs_in; first word_out=4'hA, valid 1 cycle after slot 3.
REQ-033 LOCKED, word_ready=0 for 3 frames of 4'h3, 4'h5, 4'h6 -> word_out stays 4'h3; overrun pulses twice; after word_ready=1, 4'h3 is accepted.
REQ-034 LOCKED, fs_in dropped for 1 frame -> lock stays 1; fs_in dropped for 2 consecutive frames -> lock=0 and state HUNT.
REQ-035 LOCKED, fs_in injected at slot 2 -> lock=0 the next cycle, the partial word is discarded, and lock=1 again after the following aligned fs_in.
REQ-036 PARITY_EN build, word 4'h7 with slot 4=1 -> parity_err=0; same word with slot 4=0 -> parity_err=1 with word_valid=1.
REQ-037 reset=0 asserted at slot 2 of a LOCKED frame with a buffered word -> next cycle word_valid=0, lock=0, overrun=0.
